int_to_float_param: RTL and testbench

Parametrised integer-to-IEEE-754 converter. It accepts a signed or unsigned integer of configurable width and produces a binary floating-point result of configurable exponent and fraction width, with four selectable rounding modes and inexact/overflow flags. It sits between integer datapaths and the FPU cores and uses the same stb/ack streaming handshake. It supports any binary format (half, single, double, custom), including formats where the integer range exceeds the float range.

---
 rtl/int_to_float_param_if.sv | 28 ++
 rtl/int_to_float_param.sv | 155 +++++++++++++++
 tb/tb_int_to_float_param.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/int_to_float_param_if.sv
// Stream bundle for the integer-to-float converter: operand stb/ack in, result stb/ack out.
// The master drives operands and consumes results; the slave is the converter.
interface int_to_float_param_if #(
  parameter int INT_WIDTH = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
);
  logic [INT_WIDTH-1:0]           input_a;
  logic                           input_a_signed;
  logic [1:0]                     input_a_rm;
  logic                           input_a_stb;
  logic                           input_a_ack;
  logic [EXP_WIDTH+MAN_WIDTH:0]   output_z;
  logic                           output_z_inexact;
  logic                           output_z_overflow;
  logic                           output_z_stb;
  logic                           output_z_ack;

  modport master (
    output input_a, input_a_signed, input_a_rm, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_inexact, output_z_overflow, output_z_stb
  );

  modport slave (
    input  input_a, input_a_signed, input_a_rm, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_inexact, output_z_overflow, output_z_stb
  );
endinterface

// File: rtl/int_to_float_param.sv
// Integer to IEEE-754 converter, 4 rounding modes; result stb rises 4 edges after accept.
// One conversion in flight; the result is held in PUT until output_z_ack, operands are refused meanwhile.
module int_to_float_param #(
  parameter int INT_WIDTH = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  int_to_float_param_if.slave   bus
);
  localparam int CW  = $clog2(INT_WIDTH) + 1;
  localparam int EW  = ((CW > EXP_WIDTH) ? CW : EXP_WIDTH) + 1;
  localparam int NW  = INT_WIDTH + MAN_WIDTH + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_WIDTH) - 1);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, PACK, PUT} state_t;
  state_t state;

  logic [INT_WIDTH-1:0] a_r;
  logic                 sgn_r;
  logic [1:0]           rm_r;
  logic                 sign;
  logic                 zero;
  logic [INT_WIDTH-1:0] mag;
  logic [EW-1:0]        e;
  logic [MAN_WIDTH:0]   m;
  logic                 g;
  logic                 s;

  logic [CW-1:0]        lz;
  logic [NW-1:0]        norm_w;
  logic                 round_up;
  logic [MAN_WIDTH+1:0] m_inc;
  logic [EW-1:0]        biased;
  logic                 ovf_w;
  logic [EXP_WIDTH+MAN_WIDTH:0] inf_w;
  logic [EXP_WIDTH+MAN_WIDTH:0] maxf_w;

  // Highest set bit wins because the scan runs upward.
  always_comb begin
    lz = '0;
    for (int i = 0; i < INT_WIDTH; i++) begin
      if (mag[i]) lz = CW'(INT_WIDTH - 1 - i);
    end
  end

  // Zero padding keeps the significand slice valid when INT_WIDTH is narrower than it.
  assign norm_w = {mag << lz, {(MAN_WIDTH + 2){1'b0}}};

  always_comb begin
    round_up = 1'b0;
    case (rm_r)
      2'b00:   round_up = g && (s || m[0]);
      2'b01:   round_up = 1'b0;
      2'b10:   round_up = (g || s) && !sign;
      default: round_up = (g || s) && sign;
    endcase
  end

  assign m_inc  = {1'b0, m} + (MAN_WIDTH + 2)'(1);
  assign biased = e + BIAS;
  assign ovf_w  = biased >= EMAX;
  assign inf_w  = {sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
  assign maxf_w = {sign, {(EXP_WIDTH - 1){1'b1}}, 1'b0, {MAN_WIDTH{1'b1}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      bus.input_a_ack       <= 1'b0;
      bus.output_z_stb      <= 1'b0;
      bus.output_z          <= '0;
      bus.output_z_inexact  <= 1'b0;
      bus.output_z_overflow <= 1'b0;
      a_r   <= '0;
      sgn_r <= 1'b0;
      rm_r  <= 2'b00;
      sign  <= 1'b0;
      zero  <= 1'b0;
      mag   <= '0;
      e     <= '0;
      m     <= '0;
      g     <= 1'b0;
      s     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.input_a_ack && bus.input_a_stb) begin
            a_r             <= bus.input_a;
            sgn_r           <= bus.input_a_signed;
            rm_r            <= bus.input_a_rm;
            bus.input_a_ack <= 1'b0;
            state           <= ABS;
          end else begin
            bus.input_a_ack <= 1'b1;
          end
        end
        ABS: begin
          sign  <= sgn_r && a_r[INT_WIDTH-1];
          mag   <= (sgn_r && a_r[INT_WIDTH-1]) ? -a_r : a_r;
          zero  <= (a_r == '0);
          state <= NORM;
        end
        NORM: begin
          e     <= EW'(INT_WIDTH - 1) - EW'(lz);
          m     <= norm_w[NW-1 -: MAN_WIDTH+1];
          g     <= norm_w[NW-MAN_WIDTH-2];
          s     <= |norm_w[NW-MAN_WIDTH-3:0];
          state <= ROUND;
        end
        ROUND: begin
          if (round_up) begin
            if (m_inc[MAN_WIDTH+1]) begin
              m <= {1'b1, {MAN_WIDTH{1'b0}}};
              e <= e + EW'(1);
            end else begin
              m <= m_inc[MAN_WIDTH:0];
            end
          end
          state <= PACK;
        end
        PACK: begin
          if (zero) begin
            bus.output_z          <= '0;
            bus.output_z_inexact  <= 1'b0;
            bus.output_z_overflow <= 1'b0;
          end else if (ovf_w) begin
            bus.output_z_inexact  <= 1'b1;
            bus.output_z_overflow <= 1'b1;
            case (rm_r)
              2'b00:   bus.output_z <= inf_w;
              2'b01:   bus.output_z <= maxf_w;
              2'b10:   bus.output_z <= sign ? maxf_w : inf_w;
              default: bus.output_z <= sign ? inf_w : maxf_w;
            endcase
          end else begin
            bus.output_z          <= {sign, biased[EXP_WIDTH-1:0], m[MAN_WIDTH-1:0]};
            bus.output_z_inexact  <= g || s;
            bus.output_z_overflow <= 1'b0;
          end
          bus.output_z_stb <= 1'b1;
          state            <= PUT;
        end
        PUT: begin
          if (bus.output_z_stb && bus.output_z_ack) begin
            bus.output_z_stb <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_to_float_param.sv
// Directed-vector bench: single-precision and half-precision (32-bit integer) converters.
module tb_int_to_float_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_to_float_param_if #(.INT_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) bus_sp ();
  int_to_float_param_if #(.INT_WIDTH(32), .EXP_WIDTH(5), .MAN_WIDTH(10)) bus_hp ();

  int_to_float_param #(.INT_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) u_sp (
    .clk (clk), .rst (rst), .bus (bus_sp)
  );
  int_to_float_param #(.INT_WIDTH(32), .EXP_WIDTH(5), .MAN_WIDTH(10)) u_hp (
    .clk (clk), .rst (rst), .bus (bus_hp)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ack(input int sel);
    return (sel != 0) ? bus_hp.input_a_ack : bus_sp.input_a_ack;
  endfunction
  function automatic logic get_stb(input int sel);
    return (sel != 0) ? bus_hp.output_z_stb : bus_sp.output_z_stb;
  endfunction
  function automatic logic [63:0] get_z(input int sel);
    return (sel != 0) ? 64'(bus_hp.output_z) : 64'(bus_sp.output_z);
  endfunction
  function automatic logic get_inx(input int sel);
    return (sel != 0) ? bus_hp.output_z_inexact : bus_sp.output_z_inexact;
  endfunction
  function automatic logic get_ovf(input int sel);
    return (sel != 0) ? bus_hp.output_z_overflow : bus_sp.output_z_overflow;
  endfunction

  task automatic drive(input int sel, input logic [31:0] a, input logic sgn,
                       input logic [1:0] rm, input logic stb);
    if (sel != 0) begin
      bus_hp.input_a = a; bus_hp.input_a_signed = sgn;
      bus_hp.input_a_rm = rm; bus_hp.input_a_stb = stb;
    end else begin
      bus_sp.input_a = a; bus_sp.input_a_signed = sgn;
      bus_sp.input_a_rm = rm; bus_sp.input_a_stb = stb;
    end
  endtask

  task automatic set_zack(input int sel, input logic v);
    if (sel != 0) bus_hp.output_z_ack = v;
    else          bus_sp.output_z_ack = v;
  endtask

  task automatic wait_ack(input int sel, input string tag);
    int w = 0;
    while (!get_ack(sel) && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "/ack"}, 64'(get_ack(sel)), 64'd1);
  endtask

  // Full transfer: accept, latency, result, optional stall, completion.
  task automatic convert(input int sel, input string tag, input logic [31:0] a,
                         input logic sgn, input logic [1:0] rm, input logic [63:0] ez,
                         input logic ei, input logic eo, input int hold);
    int lat = 0;
    logic stable = 1'b1;
    logic [63:0] z0;
    wait_ack(sel, tag);
    drive(sel, a, sgn, rm, 1'b1);
    @(posedge clk); #1;
    drive(sel, ~a, ~sgn, ~rm, 1'b0);
    while (!get_stb(sel) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "/lat"}, 64'(lat), 64'd4);
    check({tag, "/z"}, get_z(sel), ez);
    check({tag, "/inx"}, 64'(get_inx(sel)), 64'(ei));
    check({tag, "/ovf"}, 64'(get_ovf(sel)), 64'(eo));
    z0 = get_z(sel);
    repeat (hold) begin
      @(posedge clk); #1;
      if (!get_stb(sel) || get_z(sel) !== z0) stable = 1'b0;
    end
    if (hold > 0) check({tag, "/stall"}, 64'(stable), 64'd1);
    set_zack(sel, 1'b1);
    @(posedge clk); #1;
    set_zack(sel, 1'b0);
    check({tag, "/stb_fall"}, 64'(get_stb(sel)), 64'd0);
    check({tag, "/ack_late"}, 64'(get_ack(sel)), 64'd0);
  endtask

  initial begin
    logic seen;
    drive(0, 32'h0, 1'b0, 2'b00, 1'b0);
    drive(1, 32'h0, 1'b0, 2'b00, 1'b0);
    set_zack(0, 1'b0);
    set_zack(1, 1'b0);
    #12;
    check("rst/ack", 64'(bus_sp.input_a_ack), 64'd0);
    check("rst/stb", 64'(bus_sp.output_z_stb), 64'd0);
    check("rst/z", 64'(bus_sp.output_z), 64'd0);
    check("rst/flags", 64'({bus_sp.output_z_inexact, bus_sp.output_z_overflow}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rel/ack_low", 64'(bus_sp.input_a_ack), 64'd0);
    @(posedge clk); #1;
    check("rel/ack_rise", 64'(bus_sp.input_a_ack), 64'd1);

    convert(0, "sp_zero",     32'h00000000, 1'b0, 2'b00, 64'h00000000, 1'b0, 1'b0, 0);
    convert(0, "sp_m1",       32'hFFFFFFFF, 1'b1, 2'b00, 64'hBF800000, 1'b0, 1'b0, 0);
    convert(0, "sp_minint",   32'h80000000, 1'b1, 2'b00, 64'hCF000000, 1'b0, 1'b0, 0);
    convert(0, "sp_tie_rup",  32'h01000001, 1'b0, 2'b10, 64'h4B800001, 1'b1, 1'b0, 0);
    convert(0, "sp_tie_rdn",  32'h01000001, 1'b0, 2'b11, 64'h4B800000, 1'b1, 1'b0, 0);
    convert(0, "sp_carry",    32'hFFFFFFFF, 1'b0, 2'b00, 64'h4F800000, 1'b1, 1'b0, 0);
    convert(0, "sp_neg_rdn",  32'h80000001, 1'b1, 2'b11, 64'hCF000000, 1'b1, 1'b0, 0);
    convert(0, "sp_neg_rtz",  32'h80000001, 1'b1, 2'b01, 64'hCEFFFFFF, 1'b1, 1'b0, 0);
    convert(0, "sp_three",    32'h00000003, 1'b1, 2'b01, 64'h40400000, 1'b0, 1'b0, 0);
    convert(0, "sp_tie_rne",  32'h01000001, 1'b0, 2'b00, 64'h4B800000, 1'b1, 1'b0, 0);

    // Abort a conversion while it is in NORM; the held result and flags must clear at once.
    wait_ack(0, "abort");
    drive(0, 32'h12345678, 1'b0, 2'b00, 1'b1);
    @(posedge clk); #1;
    drive(0, 32'h0, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort/ack", 64'(bus_sp.input_a_ack), 64'd0);
    check("abort/stb", 64'(bus_sp.output_z_stb), 64'd0);
    check("abort/z", 64'(bus_sp.output_z), 64'd0);
    check("abort/inx", 64'(bus_sp.output_z_inexact), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus_sp.output_z_stb) seen = 1'b1;
    end
    check("abort/no_result", 64'(seen), 64'd0);
    convert(0, "sp_one",      32'h00000001, 1'b0, 2'b00, 64'h3F800000, 1'b0, 1'b0, 0);

    convert(1, "hp_ovf_rne",  32'h00010000, 1'b0, 2'b00, 64'h7C00, 1'b1, 1'b1, 0);
    convert(1, "hp_ovf_rtz",  32'h00010000, 1'b0, 2'b01, 64'h7BFF, 1'b1, 1'b1, 0);
    convert(1, "hp_neg_rup",  32'hFFFF0000, 1'b1, 2'b10, 64'hFBFF, 1'b1, 1'b1, 0);
    convert(1, "hp_neg_rdn",  32'hFFFF0000, 1'b1, 2'b11, 64'hFC00, 1'b1, 1'b1, 0);
    convert(1, "hp_rnd_ovf",  32'h0000FFFF, 1'b0, 2'b00, 64'h7C00, 1'b1, 1'b1, 0);
    convert(1, "hp_top_rtz",  32'h0000FFFF, 1'b0, 2'b01, 64'h7BFF, 1'b1, 1'b0, 0);
    convert(1, "hp_stall",    32'h00000800, 1'b0, 2'b00, 64'h6800, 1'b0, 1'b0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
